// File: rtl/rf_wb_sched_if.sv
// Signal bundle between the issue/write-back pipeline, the MDU and the
// register-file write-back scheduler.
interface rf_wb_sched_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  Iss_v;
    logic                  Iss_Long;
    logic [ADDR_WIDTH-1:0] Iss_Rs1_Addr;
    logic [ADDR_WIDTH-1:0] Iss_Rs2_Addr;
    logic [ADDR_WIDTH-1:0] Iss_Rd_Addr;
    logic                  Hazard_Stall;
    logic                  Wb_v;
    logic [ADDR_WIDTH-1:0] Wb_Rd_Addr;
    logic [DATA_WIDTH-1:0] Wb_Rd_Data;
    logic                  Mdu_v;
    logic                  Mdu_Rdy;
    logic [ADDR_WIDTH-1:0] Mdu_Rd_Addr;
    logic [DATA_WIDTH-1:0] Mdu_Rd_Data;
    logic                  Wb_Hold;
    logic                  Proto_Err;
    logic                  Reg_w;
    logic [ADDR_WIDTH-1:0] Rd_Addr;
    logic [DATA_WIDTH-1:0] Rd_Data;

    modport master (
        output Iss_v, Iss_Long, Iss_Rs1_Addr, Iss_Rs2_Addr, Iss_Rd_Addr,
               Wb_v, Wb_Rd_Addr, Wb_Rd_Data, Mdu_v, Mdu_Rd_Addr, Mdu_Rd_Data,
        input  Hazard_Stall, Mdu_Rdy, Wb_Hold, Proto_Err, Reg_w, Rd_Addr, Rd_Data
    );

    modport slave (
        input  Iss_v, Iss_Long, Iss_Rs1_Addr, Iss_Rs2_Addr, Iss_Rd_Addr,
               Wb_v, Wb_Rd_Addr, Wb_Rd_Data, Mdu_v, Mdu_Rd_Addr, Mdu_Rd_Data,
        output Hazard_Stall, Mdu_Rdy, Wb_Hold, Proto_Err, Reg_w, Rd_Addr, Rd_Data
    );
endinterface

// File: rtl/rf_wb_sched.sv
// Register-file write-port arbiter: pipeline write-back wins, MDU results are
// buffered, and a busy scoreboard stalls issue on hazards with in-flight MDU ops.
module rf_wb_sched #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int GPR_SIZE   = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int MAX_WAIT   = 8
) (
    input logic          clk,
    input logic          rst,
    rf_wb_sched_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(MAX_WAIT);
    localparam logic [AGE_W-1:0] AGE_HOLD = AGE_W'(MAX_WAIT - 1);

    logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [AGE_W-1:0]      age;
    logic [GPR_SIZE-1:0]   busy;
    logic [GPR_SIZE-1:0]   busy_next;
    logic                  hold;
    logic                  proto_err;
    logic                  reg_w;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  issue_set;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    assign empty     = (count == '0);
    assign bus.Mdu_Rdy = (count != CNT_FULL);
    assign push      = bus.Mdu_v && bus.Mdu_Rdy;
    assign pop       = !bus.Wb_v && !empty;
    assign head_addr = fifo_addr[rd_ptr];
    assign head_data = fifo_data[rd_ptr];

    // No bypass of a same-cycle clear: the stall looks only at registered busy bits.
    assign bus.Hazard_Stall = bus.Iss_v && (busy[bus.Iss_Rs1_Addr] ||
                                            busy[bus.Iss_Rs2_Addr] ||
                                            busy[bus.Iss_Rd_Addr]);
    assign issue_set = bus.Iss_v && bus.Iss_Long && !bus.Hazard_Stall &&
                       (bus.Iss_Rd_Addr != '0);

    // Set is applied after clear so a new owner of the same register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (pop)       busy_next[head_addr]       = 1'b0;
        if (issue_set) busy_next[bus.Iss_Rd_Addr] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.Mdu_Rd_Addr;
            fifo_data[wr_ptr] <= bus.Mdu_Rd_Data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            age       <= '0;
            busy      <= '0;
            hold      <= 1'b0;
            proto_err <= 1'b0;
            reg_w     <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            busy  <= busy_next;

            if (pop || empty)      age <= '0;
            else if (age != AGE_SAT) age <= age + AGE_W'(1);

            if (pop)                            hold <= 1'b0;
            else if (!empty && age == AGE_HOLD) hold <= 1'b1;

            if (bus.Wb_v && hold) proto_err <= 1'b1;

            // Write-port stage: x0 targets are consumed but never written.
            if (bus.Wb_v) begin
                reg_w   <= (bus.Wb_Rd_Addr != '0);
                rd_addr <= bus.Wb_Rd_Addr;
                rd_data <= bus.Wb_Rd_Data;
            end else if (pop) begin
                reg_w   <= (head_addr != '0);
                rd_addr <= head_addr;
                rd_data <= head_data;
            end else begin
                reg_w   <= 1'b0;
            end
        end
    end

    assign bus.Wb_Hold   = hold;
    assign bus.Proto_Err = proto_err;
    assign bus.Reg_w     = reg_w;
    assign bus.Rd_Addr   = rd_addr;
    assign bus.Rd_Data   = rd_data;
endmodule
